// File: rtl/teste2_can_id_decoder.sv
// teste2_can_id_decoder: CAN 2.0A/2.0B arbitration-field decoder (SOF, ID, SRR/RTR, IDE).
// Optional bit destuffing over the decoded fields when CAN_DESTUFF_EN is defined.
module teste2_can_id_decoder (
    input  logic        sample,
    input  logic        rst_n,
    input  logic        can_data,
    output logic [10:0] bit_id_11,
    output logic [28:0] bit_id_29,
    output logic [1:0]  srr_rtr_ide,
    output logic        std_frame,
    output logic        ext_frame,
    output logic        data_frame,
    output logic        remote_frame,
    output logic        rtr_ext,
    output logic        getframe
);
    typedef enum logic [2:0] {HUNT, BASE_ID, CTRL, IDE, EXT_ID, EXT_RTR, WAIT_IDLE} state_t;
    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [28:0] id_q;
    logic        ctrl_q;
    logic        stuff;
    logic        stuff_err;
`ifdef CAN_DESTUFF_EN
    logic        run_bit_q;
    logic [2:0]  run_cnt_q;
    logic        in_field;
    always_comb begin
        in_field  = state_q inside {BASE_ID, CTRL, IDE, EXT_ID, EXT_RTR};
        stuff     = in_field && run_cnt_q == 3'd5;
        stuff_err = stuff && can_data == run_bit_q;
    end
    // HUNT preloads the run with the dominant SOF bit so stuffing counts from SOF.
    always_ff @(posedge sample or negedge rst_n) begin
        if (!rst_n) begin
            run_bit_q <= 1'b0;
            run_cnt_q <= 3'd0;
        end else if (state_q == HUNT) begin
            run_bit_q <= 1'b0;
            run_cnt_q <= 3'd1;
        end else if (in_field) begin
            run_bit_q <= can_data;
            run_cnt_q <= (!stuff && can_data == run_bit_q) ? run_cnt_q + 3'd1 : 3'd1;
        end
    end
`else
    assign stuff     = 1'b0;
    assign stuff_err = 1'b0;
`endif
    always_ff @(posedge sample or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            cnt_q        <= 5'd0;
            id_q         <= 29'd0;
            ctrl_q       <= 1'b0;
            bit_id_11    <= 11'd0;
            bit_id_29    <= 29'd0;
            srr_rtr_ide  <= 2'b00;
            std_frame    <= 1'b0;
            ext_frame    <= 1'b0;
            data_frame   <= 1'b0;
            remote_frame <= 1'b0;
            rtr_ext      <= 1'b0;
            getframe     <= 1'b0;
        end else begin
            getframe <= 1'b0;
            if (stuff) begin
                if (stuff_err) state_q <= HUNT;
            end else begin
                case (state_q)
                    HUNT: if (!can_data) begin
                        state_q <= BASE_ID;
                        cnt_q   <= 5'd0;
                    end
                    BASE_ID: begin
                        id_q  <= {id_q[27:0], can_data};
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd10) begin
                            state_q <= CTRL;
                            cnt_q   <= 5'd0;
                        end
                    end
                    CTRL: begin
                        ctrl_q  <= can_data;
                        state_q <= IDE;
                    end
                    IDE: if (can_data) begin
                        state_q <= EXT_ID;
                    end else begin
                        std_frame    <= 1'b1;
                        ext_frame    <= 1'b0;
                        remote_frame <= ctrl_q;
                        data_frame   <= ~ctrl_q;
                        rtr_ext      <= 1'b0;
                        bit_id_11    <= id_q[10:0];
                        bit_id_29    <= {id_q[10:0], 18'h0};
                        srr_rtr_ide  <= {ctrl_q, 1'b0};
                        getframe     <= 1'b1;
                        state_q      <= WAIT_IDLE;
                        cnt_q        <= 5'd0;
                    end
                    EXT_ID: begin
                        id_q  <= {id_q[27:0], can_data};
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd17) begin
                            state_q <= EXT_RTR;
                            cnt_q   <= 5'd0;
                        end
                    end
                    EXT_RTR: begin
                        std_frame    <= 1'b0;
                        ext_frame    <= 1'b1;
                        remote_frame <= can_data;
                        data_frame   <= ~can_data;
                        rtr_ext      <= can_data;
                        bit_id_11    <= id_q[28:18];
                        bit_id_29    <= id_q;
                        srr_rtr_ide  <= {ctrl_q, 1'b1};
                        getframe     <= 1'b1;
                        state_q      <= WAIT_IDLE;
                        cnt_q        <= 5'd0;
                    end
                    WAIT_IDLE: begin
                        cnt_q <= can_data ? cnt_q + 5'd1 : 5'd0;
                        if (can_data && cnt_q == 5'd6) state_q <= HUNT;
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_teste2_can_id_decoder.sv
// tb_teste2_can_id_decoder: directed vector table plus idle-gating and mid-frame reset sequences.
module tb_teste2_can_id_decoder;
    logic        sample = 1'b0;
    logic        rst_n = 1'b0;
    logic        can_data = 1'b1;
    logic [10:0] bit_id_11;
    logic [28:0] bit_id_29;
    logic [1:0]  srr_rtr_ide;
    logic        std_frame, ext_frame, data_frame, remote_frame, rtr_ext, getframe;

    teste2_can_id_decoder dut (
        .sample(sample), .rst_n(rst_n), .can_data(can_data),
        .bit_id_11(bit_id_11), .bit_id_29(bit_id_29), .srr_rtr_ide(srr_rtr_ide),
        .std_frame(std_frame), .ext_frame(ext_frame), .data_frame(data_frame),
        .remote_frame(remote_frame), .rtr_ext(rtr_ext), .getframe(getframe)
    );

    always #5 sample = ~sample;

    int n_cmp = 0, n_bad = 0, gf_cnt = 0, gf_at = -1, bit_idx = 0;
    logic [46:0] snap;

    // {id11, id29, srr_rtr_ide, std, ext, data, remote, rtr_ext}
    function automatic logic [46:0] outs();
        return {bit_id_11, bit_id_29, srr_rtr_ide, std_frame, ext_frame, data_frame, remote_frame, rtr_ext};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge sample);
        can_data = b;
        @(posedge sample);
        #1;
        if (getframe === 1'b1) begin
            gf_cnt++;
            gf_at = bit_idx;
            snap  = outs();
        end
        bit_idx++;
    endtask

    task automatic send(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic start();
        gf_cnt  = 0;
        gf_at   = -1;
        bit_idx = 0;
        snap    = '0;
    endtask

    typedef struct {
        string       name;
        logic [63:0] bits;
        int          n;
        int          gf;
        logic [46:0] exp;
    } vec_t;
    vec_t tv[6];

    initial begin
        tv[0] = '{"std_data",   64'({5'b11111, 1'b0, 11'h551, 2'b00}), 19, 18,
                  {11'h551, 29'h15440000, 2'b00, 5'b10100}};
        tv[1] = '{"std_remote", 64'({5'b11111, 1'b0, 11'h551, 2'b10}), 19, 18,
                  {11'h551, 29'h15440000, 2'b10, 5'b10010}};
        tv[2] = '{"ext_remote", 64'({2'b11, 1'b0, 11'h552, 2'b11, 18'h08320, 1'b1, 1'b0}), 36, 34,
                  {11'h552, 29'h15488320, 2'b11, 5'b01011}};
        tv[3] = '{"ext_data",   64'({2'b11, 1'b0, 11'h552, 2'b11, 18'h08320, 1'b0, 1'b0}), 36, 34,
                  {11'h552, 29'h15488320, 2'b11, 5'b01100}};
        tv[4] = '{"ext_srr0",   64'({1'b0, 11'h000, 2'b01, 18'h3FFFF, 1'b0}), 33, 32,
                  {11'h000, 29'h0003FFFF, 2'b01, 5'b01100}};
        tv[5] = '{"std_7ff",    64'({1'b0, 11'h7FF, 2'b10}), 14, 13,
                  {11'h7FF, 29'h1FFC0000, 2'b10, 5'b10010}};

        #12;
        chk("reset_outs", 64'(outs()), 64'd0);
        chk("reset_getframe", 64'(getframe), 64'd0);
        @(negedge sample);
        rst_n = 1'b1;
        start();
        send(64'h7, 3);
        chk("idle_outs_zero", 64'(outs()), 64'd0);

        for (int k = 0; k < 6; k++) begin
            start();
            send(tv[k].bits, tv[k].n);
            chk({tv[k].name, "_gf_count"}, 64'(gf_cnt), 64'd1);
            chk({tv[k].name, "_gf_edge"}, 64'(gf_at), 64'(tv[k].gf));
            chk({tv[k].name, "_outs"}, 64'(snap), 64'(tv[k].exp));
            send(64'h7F, 7);
        end

        // Dominant bits before 7 recessive ones must not start a new frame.
        start();
        send(64'({1'b0, 11'h551, 2'b00}), 14);
        send(64'h3F, 6);
        send(64'({1'b0, 11'h0AA, 2'b00}), 14);
        chk("gate_gf_count", 64'(gf_cnt), 64'd1);
        chk("gate_hold_outs", 64'(outs()), 64'({11'h551, 29'h15440000, 2'b00, 5'b10100}));
        start();
        send(64'h7F, 7);
        send(64'({1'b0, 11'h123, 2'b00}), 14);
        chk("gate_new_gf_count", 64'(gf_cnt), 64'd1);
        chk("gate_new_gf_edge", 64'(gf_at), 64'd20);
        chk("gate_new_outs", 64'(snap), 64'({11'h123, 29'h048C0000, 2'b00, 5'b10100}));
        send(64'h7F, 7);

        // Asynchronous reset in the middle of BASE_ID.
        start();
        send(64'({1'b0, 5'b10101}), 6);
        @(negedge sample);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outs", 64'(outs()), 64'd0);
        chk("midrst_getframe", 64'(getframe), 64'd0);
        can_data = 1'b0;
        @(posedge sample);
        #1;
        chk("midrst_hold_getframe", 64'(getframe), 64'd0);
        @(negedge sample);
        can_data = 1'b1;
        rst_n = 1'b1;
        start();
        send(64'h7, 3);
        send(64'({1'b0, 11'h2AB, 2'b10}), 14);
        chk("midrst_gf_count", 64'(gf_cnt), 64'd1);
        chk("midrst_gf_edge", 64'(gf_at), 64'd16);
        chk("midrst_outs_after", 64'(snap), 64'({11'h2AB, 29'h0AAC0000, 2'b10, 5'b10010}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/teste2_can_id_decoder.md
# teste2_can_id_decoder

Serial CAN 2.0A/2.0B arbitration-field decoder (DUT `teste2`). It sits behind the CAN receiver's bit-timing logic and consumes one sampled bus bit per `sample` edge. It detects start-of-frame and extracts the 11-bit base or 29-bit extended identifier. It then classifies the frame as standard/extended and data/remote, and pulses `getframe` when the classification is complete.

## Interface
- No parameters.
- `sample` in 1: clock. Rising edge samples `can_data` (one edge per CAN bit).
- `rst_n` in 1: asynchronous, active-low reset.
- `can_data` in 1: sampled bus level; 0 = dominant, 1 = recessive.
- `bit_id_11` out 11: base identifier, MSB first on the wire.
- `bit_id_29` out 29: {base ID, 18-bit ID extension}.
- `srr_rtr_ide` out 2: {bit after ID, IDE bit}. This is {RTR, IDE} for standard frames and {SRR, IDE} for extended frames.
- `std_frame` out 1: last decoded frame had IDE=0.
- `ext_frame` out 1: last decoded frame had IDE=1.
- `data_frame` out 1: last decoded frame had RTR=0.
- `remote_frame` out 1: last decoded frame had RTR=1.
- `rtr_ext` out 1: RTR bit of an extended frame; 0 for standard frames.
- `getframe` out 1: one-`sample`-period pulse; all outputs above are valid while it is high.

## Operation
- FSM states: HUNT, BASE_ID, CTRL, IDE, EXT_ID, EXT_RTR, WAIT_IDLE. Reset state is HUNT.
- HUNT:
  - Recessive bits are ignored.
  - A dominant bit is SOF; go to BASE_ID with bit counter 0.
  - HUNT is armed immediately after reset; no idle period is required.
- BASE_ID: shift in 11 bits MSB-first into an internal ID register, then go to CTRL.
- CTRL: capture the bit as `srr_rtr_ide[1]`, then go to IDE.
- IDE: capture the bit as `srr_rtr_ide[0]`.
  - IDE=0 (standard frame), on this same edge:
    - `std_frame`=1, `ext_frame`=0.
    - `remote_frame`=CTRL bit, `data_frame`=~CTRL bit, `rtr_ext`=0.
    - `bit_id_11`=ID, `bit_id_29`={ID,18'h0}.
    - `getframe`=1; go to WAIT_IDLE.
  - IDE=1 (extended frame): go to EXT_ID. The SRR value does not affect the decision.
- EXT_ID: shift in 18 bits MSB-first, then go to EXT_RTR.
- EXT_RTR, on this edge:
  - `ext_frame`=1, `std_frame`=0.
  - `rtr_ext`=bit, `remote_frame`=bit, `data_frame`=~bit.
  - `bit_id_11`=base ID, `bit_id_29`={base ID, extension}.
  - `getframe`=1; go to WAIT_IDLE.
- WAIT_IDLE:
  - Count consecutive recessive bits; any dominant bit restarts the count at 0.
  - After 7 consecutive recessive bits, return to HUNT.
  - This keeps the remainder of the frame (r1/r0, DLC, data, CRC) from being taken as SOF.
- Classification outputs hold their values until the next `getframe` edge. The internal ID and capture registers may change during a frame without affecting the outputs.

## Timing
- SOF is sampled on edge 0 and ID bits on edges 1–11.
- CTRL is sampled on edge 12 and IDE on edge 13.
- EXT_ID occupies edges 14–31 and EXT_RTR is edge 32.
- Latency, counted from the SOF edge:
  - Standard frame: outputs and `getframe` update on the edge that samples IDE (edge 13).
  - Extended frame: they update on the edge that samples RTR (edge 32).
- `getframe` is high for exactly one `sample` period and cleared on the next edge. All flags are valid and stable at its rising edge.
- Exactly one of `std_frame`/`ext_frame` is 1 after the first decode, and likewise for `data_frame`/`remote_frame`.
- Reset:
  - All outputs are 0 after reset. All flags stay 0 until the first decode.
  - `rst_n` low at any point, including mid-frame, immediately forces HUNT, clears counters and outputs, and suppresses `getframe`.
- All registers are clocked by the rising edge of `sample`, with asynchronous clear on `rst_n`=0.

## Configuration
- `CAN_DESTUFF_EN` defined:
  - Bit destuffing is active from SOF through the last decoded bit.
  - After 5 consecutive equal bits, the next bit is a stuff bit: it is discarded and does not advance the FSM or counters.
  - If that stuff bit equals the preceding run, it is a stuff error: go to HUNT with no `getframe` and no output change.
- Not defined: every sampled bit is a field bit, with no stuff handling.

## Test plan
- Std data:
  - Stimulus: 11111, 0, 11'h551, 00.
  - Response: `getframe` pulses on edge 13 after SOF, with `std_frame`=1, `data_frame`=1, `remote_frame`=0, `bit_id_11`=11'h551, `srr_rtr_ide`=2'b00, `rtr_ext`=0.
- Std remote:
  - Stimulus: 11111, 0, 11'h551, 10.
  - Response: `remote_frame`=1, `data_frame`=0, `srr_rtr_ide`=2'b10, `bit_id_11`=11'h551.
- Ext remote (macro undefined):
  - Stimulus: 11, 0, 11'h552, 11, 18'h08320, 1, 0.
  - Response: `getframe` pulses on edge 32, with `ext_frame`=1, `remote_frame`=1, `rtr_ext`=1, `srr_rtr_ide`=2'b11, `bit_id_29`=29'h15488320.
- Ext data:
  - Stimulus: same as ext remote with RTR=0.
  - Response: `data_frame`=1, `rtr_ext`=0, `bit_id_29`=29'h15488320.
- Idle gating:
  - Stimulus: after a decode, dominant bits arriving before 7 recessive bits, then 7 recessive bits, then a new std frame with ID 11'h123.
  - Response: no `getframe` from the early dominant bits; the new frame is decoded with `bit_id_11`=11'h123.
- Reset mid-frame:
  - Stimulus: `rst_n` pulsed low during BASE_ID.
  - Response: all outputs are 0 and no `getframe` occurs; the following frame decodes correctly.
